// File: rtl/axi_lite_bram_ctrl_pipe.sv
// AXI-lite slave in front of a dual-port BRAM. Reads and writes use separate
// BRAM ports so both channels can complete in the same cycle.
//
// Read path : AR handshake fires the BRAM read port combinationally. A tag
//             pipe of READ_LATENCY stages tracks {valid, err}. When the tag
//             reaches the end, the beat lands in a (READ_LATENCY+2)-deep
//             response FIFO. A credit counter (in flight + queued) throttles AR
//             so the FIFO can never overflow, whatever s_rready does.
// Write path: AW and W are taken together only. The BRAM write port fires in
//             the same cycle. The response goes into a 2-entry B buffer.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*    AXI-lite write address / data / response channels
//   s_ar*/s_r*         AXI-lite read address / data channels
//   bram_rd_*          BRAM read port (data returns READ_LATENCY cycles after en)
//   bram_wr_*, bram_we BRAM write port with byte enables
module axi_lite_bram_ctrl_pipe #(
   parameter int ADDR_WIDTH      = 48,
   parameter int DATA_WIDTH      = 64,
   parameter int BRAM_ADDR_WIDTH = 16,
   parameter int READ_LATENCY    = 1,
   parameter int RANGE_CHECK     = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_WIDTH-1:0]      s_awaddr,
   input  logic                       s_awvalid,
   output logic                       s_awready,
   input  logic [DATA_WIDTH-1:0]      s_wdata,
   input  logic [DATA_WIDTH/8-1:0]    s_wstrb,
   input  logic                       s_wvalid,
   output logic                       s_wready,
   output logic [1:0]                 s_bresp,
   output logic                       s_bvalid,
   input  logic                       s_bready,
   input  logic [ADDR_WIDTH-1:0]      s_araddr,
   input  logic                       s_arvalid,
   output logic                       s_arready,
   output logic [DATA_WIDTH-1:0]      s_rdata,
   output logic [1:0]                 s_rresp,
   output logic                       s_rvalid,
   input  logic                       s_rready,
   output logic                       bram_rd_en,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_rd_addr,
   input  logic [DATA_WIDTH-1:0]      bram_rd_data,
   output logic                       bram_wr_en,
   output logic [DATA_WIDTH/8-1:0]    bram_we,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr,
   output logic [DATA_WIDTH-1:0]      bram_wr_data
);
   localparam int OFF   = $clog2(DATA_WIDTH/8);
   localparam int DEPTH = READ_LATENCY + 2;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);

   // ---------------- read path ----------------
   logic                    ar_err, ar_hs, push, pop;
   logic [CW-1:0]           credit, rcount;
   logic [READ_LATENCY-1:0] vld_pipe, err_pipe;
   logic [DATA_WIDTH-1:0]   rf_data [DEPTH];
   logic [DEPTH-1:0]        rf_err;
   logic [PW-1:0]           wptr, rptr;

   assign ar_err = (RANGE_CHECK != 0) && ((s_araddr >> (BRAM_ADDR_WIDTH + OFF)) != '0);

   // Credit only depends on registered state, never on s_rready.
   assign s_arready    = (credit < CW'(DEPTH)) && !rst;
   assign ar_hs        = s_arvalid && s_arready;
   // An out-of-range read keeps its pipeline slot but never touches the BRAM.
   assign bram_rd_en   = ar_hs && !ar_err;
   assign bram_rd_addr = ar_hs ? s_araddr[BRAM_ADDR_WIDTH+OFF-1:OFF] : '0;

   assign push     = vld_pipe[READ_LATENCY-1];
   assign pop      = s_rvalid && s_rready;
   assign s_rvalid = (rcount != '0);
   // Head is read straight out of FIFO registers, so R stays stable under stall.
   assign s_rdata  = rf_data[rptr];
   assign s_rresp  = rf_err[rptr] ? 2'b10 : 2'b00;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         err_pipe <= '0;
         credit   <= '0;
         rcount   <= '0;
         wptr     <= '0;
         rptr     <= '0;
         rf_err   <= '0;
      end else begin
         vld_pipe[0] <= ar_hs;
         err_pipe[0] <= ar_err;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            err_pipe[i] <= err_pipe[i-1];
         end
         credit <= credit + CW'(ar_hs) - CW'(pop);
         rcount <= rcount + CW'(push) - CW'(pop);
         if (push) begin
            rf_err[wptr] <= err_pipe[READ_LATENCY-1];
            wptr         <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
         end
         if (pop)
            rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      end
   end

   // Data storage needs no reset; occupancy is governed by rcount.
   always_ff @(posedge clk) begin
      if (push)
         rf_data[wptr] <= err_pipe[READ_LATENCY-1] ? '0 : bram_rd_data;
   end

   // ---------------- write path ----------------
   logic       aw_err, w_hs, b_pop;
   logic [1:0] bcount, bq0, bq1, new_resp;

   assign aw_err    = (RANGE_CHECK != 0) && ((s_awaddr >> (BRAM_ADDR_WIDTH + OFF)) != '0);
   assign w_hs      = s_awvalid && s_wvalid && (bcount < 2'd2) && !rst;
   assign s_awready = w_hs;
   assign s_wready  = w_hs;
   assign new_resp  = aw_err ? 2'b10 : 2'b00;

   // wstrb=0 still pulses bram_wr_en; only range errors suppress it.
   assign bram_wr_en   = w_hs && !aw_err;
   assign bram_we      = bram_wr_en ? s_wstrb : '0;
   assign bram_wr_addr = w_hs ? s_awaddr[BRAM_ADDR_WIDTH+OFF-1:OFF] : '0;
   assign bram_wr_data = w_hs ? s_wdata : '0;

   assign s_bvalid = (bcount != 2'd0);
   assign s_bresp  = bq0;
   assign b_pop    = s_bvalid && s_bready;

   // bq0 is the head. Enqueue with a full buffer cannot happen (w_hs needs bcount<2),
   // so a simultaneous push/pop always has exactly one entry to replace.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcount <= 2'd0;
         bq0    <= 2'b00;
         bq1    <= 2'b00;
      end else begin
         bcount <= bcount + {1'b0, w_hs} - {1'b0, b_pop};
         case ({w_hs, b_pop})
            2'b01:   bq0 <= bq1;
            2'b10:   if (bcount == 2'd0) bq0 <= new_resp;
                     else                bq1 <= new_resp;
            2'b11:   bq0 <= new_resp;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_bram_ctrl_pipe.sv
module tb_axi_lite_bram_ctrl_pipe;
   localparam int NI = 5;   // inst 0..3: READ_LATENCY 1..4, RANGE_CHECK=1; inst 4: RL=2, RANGE_CHECK=0

   logic        clk, rst;
   logic [47:0] awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;

   logic [NI-1:0]       arready_a, rvalid_a, bvalid_a, awready_a, wready_a, rd_en_a, wr_en_a;
   logic [NI-1:0][63:0] rdata_a, wr_data_a;
   logic [NI-1:0][1:0]  rresp_a, bresp_a;
   logic [NI-1:0][3:0]  rd_addr_a, wr_addr_a;
   logic [NI-1:0][7:0]  we_a;

   for (genvar g = 0; g < NI; g++) begin : gi
      localparam int RL = (g < 4) ? g + 1 : 2;
      localparam int RC = (g < 4) ? 1 : 0;
      logic [63:0] mem [16];
      logic [63:0] dpipe [RL];
      logic [63:0] rd_data;
      assign rd_data = dpipe[RL-1];
      // BRAM model; idle read port yields poison so error beats must be zeroed by the DUT
      always @(posedge clk) begin
         if (wr_en_a[g])
            for (int b = 0; b < 8; b++)
               if (we_a[g][b]) mem[wr_addr_a[g]][b*8+:8] <= wr_data_a[g][b*8+:8];
         dpipe[0] <= rd_en_a[g] ? mem[rd_addr_a[g]] : 64'hBAD0_BAD0_BAD0_BAD0;
         for (int k = 1; k < RL; k++) dpipe[k] <= dpipe[k-1];
      end
      axi_lite_bram_ctrl_pipe #(
         .ADDR_WIDTH(48), .DATA_WIDTH(64), .BRAM_ADDR_WIDTH(4),
         .READ_LATENCY(RL), .RANGE_CHECK(RC)
      ) u_dut (
         .clk(clk), .rst(rst),
         .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready_a[g]),
         .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready_a[g]),
         .s_bresp(bresp_a[g]), .s_bvalid(bvalid_a[g]), .s_bready(bready),
         .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready_a[g]),
         .s_rdata(rdata_a[g]), .s_rresp(rresp_a[g]), .s_rvalid(rvalid_a[g]), .s_rready(rready),
         .bram_rd_en(rd_en_a[g]), .bram_rd_addr(rd_addr_a[g]), .bram_rd_data(rd_data),
         .bram_wr_en(wr_en_a[g]), .bram_we(we_a[g]), .bram_wr_addr(wr_addr_a[g]),
         .bram_wr_data(wr_data_a[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int          n_tests = 0, n_fail = 0, cyc = 0;
   logic [65:0] exp_q [NI][$];
   logic [1:0]  b_q   [NI][$];
   logic [63:0] ref_mem [NI][16];
   int          ar_cnt [NI], aw_cnt [NI], beat_cnt [NI], first_c [NI], last_c [NI];

   function automatic int rl_of(input int i);
      return (i < 4) ? i + 1 : 2;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic [65:0] e;
      logic [1:0]  br;
      logic [3:0]  w;
      logic        err;
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            exp_q[i].delete();
            b_q[i].delete();
            continue;
         end
         if (rvalid_a[i] && rready) begin
            beat_cnt[i]++;
            if (beat_cnt[i] == 1) first_c[i] = cyc;
            last_c[i] = cyc;
            if (exp_q[i].size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL r_unexpected[%0d]: got beat %0h expected none", i, rdata_a[i]);
            end else begin
               e = exp_q[i].pop_front();
               chk($sformatf("r_beat[%0d]", i), {rresp_a[i], rdata_a[i]}, e);
            end
         end
         if (bvalid_a[i] && bready) begin
            if (b_q[i].size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL b_unexpected[%0d]: got bresp %0h expected none", i, bresp_a[i]);
            end else begin
               br = b_q[i].pop_front();
               chk($sformatf("b_resp[%0d]", i), bresp_a[i], br);
            end
         end
         if (arvalid && arready_a[i]) begin
            ar_cnt[i]++;
            w   = araddr[6:3];
            err = (i < 4) && (araddr[47:7] != '0);
            exp_q[i].push_back(err ? {2'b10, 64'h0} : {2'b00, ref_mem[i][w]});
         end
         if (awvalid && wvalid && awready_a[i]) begin
            aw_cnt[i]++;
            w   = awaddr[6:3];
            err = (i < 4) && (awaddr[47:7] != '0);
            if (!err)
               for (int b = 0; b < 8; b++)
                  if (wstrb[b]) ref_mem[i][w][b*8+:8] = wdata[b*8+:8];
            b_q[i].push_back(err ? 2'b10 : 2'b00);
         end
      end
      cyc++;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic fin();
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      at_neg();
      fin();
   endtask

   task automatic clear_stats();
      for (int i = 0; i < NI; i++) begin
         ar_cnt[i] = 0; aw_cnt[i] = 0; beat_cnt[i] = 0; first_c[i] = 0; last_c[i] = 0;
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < NI; i++)
         if (exp_q[i].size() != 0 || b_q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain(input string tag);
      for (int k = 0; k < 40 && pending(); k++) tick();
      for (int i = 0; i < NI; i++)
         chk($sformatf("%s_drain[%0d]", tag, i), {exp_q[i].size(), b_q[i].size()}, 0);
   endtask

   // ---------------- write vectors ----------------
   typedef struct {
      logic [47:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      logic        en;     // in range for RANGE_CHECK=1
      logic [7:0]  we;
      logic [3:0]  waddr;
      logic [1:0]  resp;
   } wvec_t;
   localparam int NV = 7;
   wvec_t tv [NV];

   initial begin
      logic [63:0] hd;
      tv[0] = '{48'h40,            64'h1122334455667788, 8'hFF, 1'b1, 8'hFF, 4'd8,  2'b00};
      tv[1] = '{48'h0B,            64'hA5A5A5A5A5A5A5A5, 8'h0F, 1'b1, 8'h0F, 4'd1,  2'b00};
      tv[2] = '{48'h10,            64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, 8'h00, 4'd2,  2'b00};
      tv[3] = '{48'h80,            64'h0000000012345678, 8'h0F, 1'b0, 8'h00, 4'd0,  2'b10};
      tv[4] = '{48'h7F,            64'hDEADBEEFCAFEF00D, 8'hF0, 1'b1, 8'hF0, 4'd15, 2'b00};
      tv[5] = '{48'h800000000040,  64'h0123456789ABCDEF, 8'hFF, 1'b0, 8'h00, 4'd8,  2'b10};
      tv[6] = '{48'h78,            64'hF0F0F0F00F0F0F0F, 8'h81, 1'b1, 8'h81, 4'd15, 2'b00};

      for (int i = 0; i < NI; i++) for (int k = 0; k < 16; k++) ref_mem[i][k] = '0;
      clear_stats();
      rst = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;

      // reset state
      tick(); tick();
      at_neg();
      chk("reset_ready", {arready_a, awready_a, wready_a}, '0);
      chk("reset_valid", {rvalid_a, bvalid_a}, '0);
      chk("reset_bram", {rd_en_a, wr_en_a, we_a}, '0);
      fin();
      rst = 1'b0;
      at_neg();
      chk("arready_after_reset", arready_a, 5'h1F);
      fin();

      // fill every word, back to back
      for (int k = 0; k < 16; k++) begin
         awaddr = 48'(k * 8); wdata = {32'hC0DE0000 | k, ~32'(k)}; wstrb = 8'hFF;
         awvalid = 1'b1; wvalid = 1'b1;
         at_neg();
         chk($sformatf("fill_aw[%0d]", k), awready_a, 5'h1F);
         fin();
      end
      awvalid = 1'b0; wvalid = 1'b0;
      drain("fill");

      // table-driven writes
      for (int t = 0; t < NV; t++) begin
         awaddr = tv[t].addr; wdata = tv[t].data; wstrb = tv[t].strb;
         awvalid = 1'b1; wvalid = 1'b1;
         at_neg();
         chk($sformatf("w%0d_hs", t), {awready_a[1], wready_a[1]}, 2'b11);
         chk($sformatf("w%0d_en_we", t), {wr_en_a[1], we_a[1]}, {tv[t].en, tv[t].we});
         if (tv[t].en)
            chk($sformatf("w%0d_addr_data", t), {wr_addr_a[1], wr_data_a[1]}, {tv[t].waddr, tv[t].data});
         chk($sformatf("w%0d_alias", t), {wr_en_a[4], we_a[4], wr_addr_a[4]}, {1'b1, tv[t].strb, tv[t].addr[6:3]});
         fin();
         awvalid = 1'b0; wvalid = 1'b0;
         at_neg();
         chk($sformatf("w%0d_b_next", t), {bvalid_a[1], bresp_a[1]}, {1'b1, tv[t].resp});
         chk($sformatf("w%0d_b_alias", t), {bvalid_a[4], bresp_a[4]}, 3'b100);
         fin();
      end
      drain("wtab");

      // read back each table address; entry 0 also checks exact latency on RL=2
      for (int t = 0; t < NV; t++) begin
         araddr = tv[t].addr; arvalid = 1'b1;
         at_neg();
         chk($sformatf("r%0d_rd_en", t), {rd_en_a[1], rd_en_a[4]}, {tv[t].en, 1'b1});
         if (tv[t].en) chk($sformatf("r%0d_rd_addr", t), rd_addr_a[1], tv[t].waddr);
         fin();
         arvalid = 1'b0;
         if (t == 0) begin
            at_neg(); chk("lat_t1", rvalid_a[1], 1'b0); fin();
            at_neg(); chk("lat_t2", rvalid_a[1], 1'b0); fin();
            at_neg();
            chk("lat_t3", {rvalid_a[1], rresp_a[1], rdata_a[1]}, {1'b1, 2'b00, 64'h1122334455667788});
            fin();
         end
         drain($sformatf("r%0d", t));
      end

      // out-of-range read at 0x80: only the aliasing instance touches BRAM (word 0)
      araddr = 48'h80; arvalid = 1'b1;
      at_neg();
      chk("oor_rd_en", rd_en_a, 5'b10000);
      chk("alias_rd_addr", rd_addr_a[4], 4'd0);
      fin();
      arvalid = 1'b0;
      drain("oor");

      // 16 back-to-back reads, rready held high
      clear_stats();
      for (int k = 0; k < 16; k++) begin
         araddr = 48'(k * 8); arvalid = 1'b1;
         if (k == 0) hd = 64'(cyc);
         at_neg();
         chk($sformatf("tp_arready[%0d]", k), arready_a, 5'h1F);
         fin();
      end
      arvalid = 1'b0;
      drain("tp");
      for (int i = 0; i < NI; i++)
         chk($sformatf("tp_stream[%0d]", i), {beat_cnt[i], last_c[i] - first_c[i], first_c[i] - int'(hd)},
             {32'd16, 32'd15, 32'(rl_of(i) + 1)});

      // rready low for 20 cycles under a read stream
      clear_stats();
      rready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         araddr = 48'((k % 16) * 8); arvalid = 1'b1;
         at_neg();
         if (k == 19) begin
            chk("stall_arready", arready_a, '0);
            chk("stall_rvalid", rvalid_a, 5'h1F);
            hd = exp_q[2][0][63:0];
            chk("stall_head_rl3", {rresp_a[2], rdata_a[2]}, {2'b00, hd});
         end
         fin();
      end
      arvalid = 1'b0;
      for (int i = 0; i < NI; i++)
         chk($sformatf("stall_accepted[%0d]", i), ar_cnt[i], rl_of(i) + 2);
      rready = 1'b1;
      drain("stall");

      // bready low with 4 writes offered, then AW alone
      clear_stats();
      bready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         awaddr = 48'h18; wdata = 64'h5555_0000_0000_0000 | 64'(k); wstrb = 8'hFF;
         awvalid = 1'b1; wvalid = 1'b1;
         at_neg();
         if (k >= 2) chk($sformatf("bfull_ready[%0d]", k), {awready_a, wready_a}, '0);
         fin();
      end
      chk("bfull_accepted", aw_cnt[0], 2);
      wvalid = 1'b0; bready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         at_neg();
         chk($sformatf("aw_only[%0d]", k), {awready_a, wready_a}, '0);
         fin();
      end
      awvalid = 1'b0;
      drain("bfull");

      // reset with reads in flight and a pending B
      bready = 1'b0; rready = 1'b0;
      awaddr = 48'h20; wdata = 64'h7777_8888_9999_AAAA; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         araddr = 48'(k * 8); arvalid = 1'b1;
         tick();
      end
      arvalid = 1'b0; rst = 1'b1;
      at_neg();
      chk("rst_arready", arready_a, '0);
      fin();
      at_neg();
      chk("rst_valids", {rvalid_a, bvalid_a}, '0);
      fin();
      rst = 1'b0; rready = 1'b1; bready = 1'b1;
      repeat (8) tick();
      araddr = 48'h40; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      drain("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
